// File: rtl/sys_out_deskew.sv
// sys_out_deskew: realigns column-staggered systolic outputs into rows, buffers them in a FIFO
module sys_out_deskew #(
    parameter int COLS       = 4,
    parameter int P_BITWIDTH = 24,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    input  logic [COLS-1:0][P_BITWIDTH-1:0]     in_data,
    input  logic                                tile_start,
    input  logic [CNT_W-1:0]                    cfg_rows,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [COLS-1:0][P_BITWIDTH-1:0]     out_data,
    output logic                                out_last,
    output logic                                stall_req,
    output logic                                overflow,
    output logic [$clog2(FIFO_DEPTH):0]         fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    typedef logic [COLS-1:0][P_BITWIDTH-1:0] row_t;

    row_t              aligned;
    logic [COLS-2:0]   vld_q;
    row_t              mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_q;
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]  row_q, row_d, rows_q, rows_d;
    logic              ovf_q, ovf_d;
    logic              aligned_valid, full, pop, push, row_last;

    genvar j;
    generate
        for (j = 0; j < COLS; j++) begin : g_col
            localparam int D = COLS - 1 - j;
            if (D == 0) begin : g_pass
                assign aligned[j] = in_data[j];
            end else begin : g_dly
                logic [D-1:0][P_BITWIDTH-1:0] sh_q;
                // Column j waits D cycles so it meets the last column of its row
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        sh_q <= '0;
                    end else begin
                        sh_q[0] <= in_data[j];
                        for (int k = 1; k < D; k++) sh_q[k] <= sh_q[k-1];
                    end
                end
                assign aligned[j] = sh_q[D-1];
            end
        end
    endgenerate

    // Row strobe delayed to match the fully aligned row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_valid;
            for (int k = 1; k < COLS - 1; k++) vld_q[k] <= vld_q[k-1];
        end
    end

    assign aligned_valid = vld_q[COLS-2];
    assign full          = cnt_q == CW'(FIFO_DEPTH);
    assign pop           = out_valid && out_ready;
    assign push          = aligned_valid && (!full || pop);
    assign row_last      = rows_q != '0 && row_q == rows_q - 1'b1;

    // Next-state for pointers, occupancy, tile row counter and sticky overflow
    always_comb begin
        wr_d   = wr_q + AW'(push);
        rd_d   = rd_q + AW'(pop);
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        ovf_d  = ovf_q || (aligned_valid && full && !pop);
        row_d  = tile_start ? '0 : aligned_valid ? (row_last ? '0 : row_q + 1'b1) : row_q;
        rows_d = tile_start ? cfg_rows : rows_q;
    end

    // FIFO storage and control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
            last_q <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            row_q  <= '0;
            rows_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q]  <= aligned;
                last_q[wr_q] <= row_last;
            end
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            row_q  <= row_d;
            rows_q <= rows_d;
        end
    end

    assign out_valid  = cnt_q != '0;
    assign out_data   = mem_q[rd_q];
    assign out_last   = last_q[rd_q];
    assign fifo_count = cnt_q;
    assign overflow   = ovf_q;
    assign stall_req  = out_valid && (32'(FIFO_DEPTH) - 32'(cnt_q) <= 32'(COLS));
endmodule
